data_ram_ctrl: RTL and testbench
================================

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: byte-address width of the attached 8-bit data RAM.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 1: access request, sampled only in IDLE.
REQ-005 SHALL have port we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have ports w, h, b, inputs, 1 each: word, half or byte size select.
REQ-007 SHALL have port z, input, 1: load zero-extend (1) or sign-extend (0).
REQ-008 SHALL have port addr, input, 32: byte address.
REQ-009 SHALL have port wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port rdata, output, 32: extended load result.
REQ-011 SHALL have port busy, output, 1: high while not in IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port addr_err, output, 1: misalignment flag, valid with done.
REQ-014 SHALL have ports ram_ena, ram_wena, output, 1 each: RAM enable and write enable.
REQ-015 SHALL have port ram_addr, output, ADDR_BITS: RAM byte address.
REQ-016 SHALL have port ram_wdata, output, 8: RAM write byte.
REQ-017 SHALL have port ram_rdata, input, 8: RAM read byte, combinational from ram_addr (asynchronous-read RAM).

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-019 SHALL, in IDLE with req=1, latch we/size/z/addr/wdata, clear the byte counter and go to ACCESS; req=0 keeps IDLE.
REQ-020 SHALL decode size with priority w > h > b; none asserted means byte. N = 4/2/1.
REQ-021 SHALL, in ACCESS, perform one byte per cycle for counter k = 0..N-1: ram_ena=1, ram_wena=we, ram_addr = (addr[ADDR_BITS-1:0] + k) mod 2^ADDR_BITS.
REQ-022 SHALL order bytes big-endian: byte k holds bits [8(N-1-k)+7 : 8(N-1-k)] of the N-byte value; stores drive ram_wdata from wdata, loads capture ram_rdata into the corresponding slot.
REQ-023 SHALL move to DONE after byte k=N-1; a request accepted at cycle t gives done=1 at cycle t+N+1, and DONE returns to IDLE the following cycle.
REQ-024 SHALL, for loads, update rdata in the DONE cycle: word unchanged; half/byte zero-extended if z=1, else sign-extended from bit 15/7. rdata holds until the next completed load.
REQ-025 SHALL leave rdata unchanged on store completion.
REQ-026 SHALL drive ram_ena=0 and ram_wena=0 in IDLE and DONE.
REQ-027 SHALL ignore req while busy=1; no queuing.
REQ-028 SHALL wrap ram_addr modulo 2^ADDR_BITS, ignoring addr bits above ADDR_BITS-1.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE and clear the counter; rdata=0, busy=0, done=0, addr_err=0, ram_ena=0, ram_wena=0, ram_addr=0, ram_wdata=0.
REQ-030 SHALL abort an access in progress on rst with no further RAM writes; a partially written word remains partially written.

Configuration
REQ-031 SHALL, with ALIGN_CHECK_EN defined, flag misalignment (h with addr[0]=1; w with addr[1:0]!=0): no RAM cycles, go straight to DONE (done at t+1), addr_err=1, rdata unchanged.
REQ-032 SHALL, without ALIGN_CHECK_EN, force addr[0]=0 for half and addr[1:0]=0 for word, perform the access, and tie addr_err to 0.

Verification
REQ-033 SHALL cover: store word 0x11223344 at 0x10 -> RAM[0x10..0x13]=11,22,33,44 over 4 cycles, done at t+5.
REQ-034 SHALL cover: load half at 0x12, z=0, RAM bytes 0x80,0x01 -> rdata=0xFFFF8001; same with z=1 -> 0x00008001.
REQ-035 SHALL cover: load byte 0xF0, z=0 -> rdata=0xFFFFFFF0, done at t+2.
REQ-036 SHALL cover: with ALIGN_CHECK_EN, load word at 0x11 -> done at t+1, addr_err=1, ram_ena never high; without it -> access at 0x10.
REQ-037 SHALL cover: req held high during a word store -> exactly one access; rst at 2nd ACCESS cycle -> only byte 0 written, IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Byte-serial load/store controller for an 8-bit asynchronous-read RAM, big-endian byte order.
// Define ALIGN_CHECK_EN to flag misaligned half/word accesses instead of force-aligning them.
module data_ram_ctrl #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic                 w,
    input  logic                 h,
    input  logic                 b,
    input  logic                 z,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 addr_err,
    output logic                 ram_ena,
    output logic                 ram_wena,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  z_q, z_d;
    logic [1:0]            last_q, last_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [23:0]           buf_q, buf_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  is_w, is_h;
    logic [1:0]            size_last;
    logic [ADDR_BITS-1:0]  base_addr;
    logic                  bad;
    logic [31:0]           full;
    logic [31:0]           ext;
    logic [1:0]            idx;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_BITS] ^ b;

    assign is_w      = w;
    assign is_h      = !w && h;
    assign size_last = is_w ? 2'd3 : (is_h ? 2'd1 : 2'd0);

`ifdef ALIGN_CHECK_EN
    assign base_addr = addr[ADDR_BITS-1:0];
    assign bad       = (is_w && (addr[1:0] != 2'b00)) || (is_h && addr[0]);
`else
    always_comb begin
        base_addr = addr[ADDR_BITS-1:0];
        if (is_w)
            base_addr[1:0] = 2'b00;
        else if (is_h)
            base_addr[0] = 1'b0;
    end
    assign bad = 1'b0;
`endif

    // The final byte lands in bits [7:0]; earlier bytes are already shifted up in buf_q.
    assign full = {buf_q, ram_rdata};

    always_comb begin
        ext = full;
        if (last_q == 2'd1)
            ext = z_q ? {16'h0000, full[15:0]} : {{16{full[15]}}, full[15:0]};
        else if (last_q == 2'd0)
            ext = z_q ? {24'h000000, full[7:0]} : {{24{full[7]}}, full[7:0]};
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        z_d     = z_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    z_d     = z;
                    last_d  = size_last;
                    addr_d  = base_addr;
                    wdata_d = wdata;
                    cnt_d   = 2'd0;
                    buf_d   = '0;
                    err_d   = bad;
                    state_d = bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                buf_d = {buf_q[15:0], ram_rdata};
                if (cnt_q == last_q) begin
                    state_d = DONE;
                    if (!we_q)
                        rdata_d = ext;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            z_q     <= 1'b0;
            last_q  <= 2'd0;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            z_q     <= z_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Enable is gated by rst so an aborted access issues no write on the reset edge.
    assign idx       = last_q - cnt_q;
    assign ram_ena   = (state_q == ACCESS) && !rst;
    assign ram_wena  = ram_ena && we_q;
    assign ram_addr  = (state_q == ACCESS) ? addr_q + ADDR_BITS'(cnt_q) : '0;
    assign ram_wdata = (state_q == ACCESS) ? wdata_q[{idx, 3'b000} +: 8] : '0;

    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign addr_err = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl with a behavioural async-read RAM.
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, w, h, b, z;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, addr_err, ram_ena, ram_wena;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    logic [7:0]  mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [7:0]  pl_data = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_ram_ctrl #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .w(w), .h(h), .b(b), .z(z),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .addr_err(addr_err), .ram_ena(ram_ena), .ram_wena(ram_wena),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (ram_ena && ram_wena)
            mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        logic        we, w, h, b, z;
        logic [31:0] addr, wdata;
        logic [9:0]  base;
        logic [31:0] pre, exp_mem, exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mkv(logic we_i, logic w_i, logic h_i, logic b_i, logic z_i,
                                 logic [31:0] a, logic [31:0] wd, logic [9:0] base,
                                 logic [31:0] pre, logic [31:0] em, logic [31:0] er, int lat);
        vec_t v;
        v.we = we_i; v.w = w_i; v.h = h_i; v.b = b_i; v.z = z_i;
        v.addr = a; v.wdata = wd; v.base = base; v.pre = pre;
        v.exp_mem = em; v.exp_rdata = er; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] base, input logic [31:0] val);
        for (int i = 0; i < 4; i++) begin
            pl_we   = 1'b1;
            pl_addr = base + 10'(i);
            pl_data = val[31 - 8*i -: 8];
            @(negedge clk);
        end
        pl_we = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] base);
        logic [9:0] a1, a2, a3;
        a1 = base + 10'd1;
        a2 = base + 10'd2;
        a3 = base + 10'd3;
        return {mem[base], mem[a1], mem[a2], mem[a3]};
    endfunction

    // Called at a negedge; drives one request and waits (bounded) for done.
    task automatic run(input logic we_i, input logic w_i, input logic h_i, input logic b_i,
                       input logic z_i, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output int ena_cnt, output logic [9:0] first_addr,
                       output logic err);
        we = we_i; w = w_i; h = h_i; b = b_i; z = z_i; addr = a; wdata = wd;
        req = 1'b1;
        lat = 99; ena_cnt = 0; first_addr = '1; err = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (ram_ena) begin
                if (ena_cnt == 0) first_addr = ram_addr;
                ena_cnt++;
            end
            if (done) begin
                lat = c;
                err = addr_err;
                break;
            end
        end
    endtask

    initial begin
        int          lat, ena_cnt, dones;
        logic [9:0]  fa;
        logic        err;
        logic [31:0] prev_rdata;

        vt[0]  = mkv(1, 1, 0, 0, 0, 32'h10,       32'h11223344, 10'h010, 32'h0,        32'h11223344, 32'h0,        5);
        vt[1]  = mkv(0, 0, 1, 0, 0, 32'h12,       32'h0,        10'h012, 32'h80010000, 32'h80010000, 32'hFFFF8001, 3);
        vt[2]  = mkv(0, 0, 1, 0, 1, 32'h12,       32'h0,        10'h012, 32'h80010000, 32'h80010000, 32'h00008001, 3);
        vt[3]  = mkv(0, 0, 0, 1, 0, 32'h20,       32'h0,        10'h020, 32'hF0000000, 32'hF0000000, 32'hFFFFFFF0, 2);
        vt[4]  = mkv(0, 1, 0, 0, 0, 32'h10,       32'h0,        10'h010, 32'h11223344, 32'h11223344, 32'h11223344, 5);
        vt[5]  = mkv(1, 0, 0, 1, 0, 32'h3FF,      32'h123456A5, 10'h3FF, 32'h0,        32'hA5000000, 32'h11223344, 2);
        vt[6]  = mkv(1, 1, 0, 0, 0, 32'h12345400, 32'hDEADBEEF, 10'h000, 32'h0,        32'hDEADBEEF, 32'h11223344, 5);
        vt[7]  = mkv(0, 0, 1, 0, 0, 32'h40,       32'h0,        10'h040, 32'h7FFF0000, 32'h7FFF0000, 32'h00007FFF, 3);
        vt[8]  = mkv(0, 0, 0, 1, 1, 32'h41,       32'h0,        10'h041, 32'hF0000000, 32'hF0000000, 32'h000000F0, 2);
        vt[9]  = mkv(0, 1, 1, 1, 0, 32'h50,       32'h0,        10'h050, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 5);
        vt[10] = mkv(0, 0, 1, 1, 0, 32'h60,       32'h0,        10'h060, 32'h8000AAAA, 32'h8000AAAA, 32'hFFFF8000, 3);
        vt[11] = mkv(0, 0, 0, 0, 0, 32'h71,       32'h0,        10'h071, 32'h7E000000, 32'h7E000000, 32'h0000007E, 2);
        vt[12] = mkv(1, 0, 1, 0, 0, 32'h90,       32'hFFFFCAFE, 10'h090, 32'h0,        32'hCAFE0000, 32'h0000007E, 3);

        rst = 1'b1; req = 1'b0; we = 1'b0; w = 1'b0; h = 1'b0; b = 1'b0; z = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_addr_err", 32'(addr_err), 32'h0);
        chk("reset_ram_ena", 32'(ram_ena), 32'h0);
        chk("reset_ram_wena", 32'(ram_wena), 32'h0);
        chk("reset_ram_addr", 32'(ram_addr), 32'h0);
        chk("reset_ram_wdata", 32'(ram_wdata), 32'h0);

        for (int i = 0; i < 13; i++) begin
            preload(vt[i].base, vt[i].pre);
            run(vt[i].we, vt[i].w, vt[i].h, vt[i].b, vt[i].z, vt[i].addr, vt[i].wdata,
                lat, ena_cnt, fa, err);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), rdata, vt[i].exp_rdata);
            chk($sformatf("v%0d_addr_err", i), 32'(err), 32'h0);
            chk($sformatf("v%0d_ram_cycles", i), 32'(ena_cnt), 32'(vt[i].exp_lat - 1));
            chk($sformatf("v%0d_first_addr", i), 32'(fa), 32'(vt[i].base));
            @(negedge clk);
            chk($sformatf("v%0d_mem", i), mem_word(vt[i].base), vt[i].exp_mem);
            chk($sformatf("v%0d_idle_after", i), 32'(busy), 32'h0);
        end

        // Misaligned word load at 0x11
        preload(10'h010, 32'h01020304);
        prev_rdata = rdata;
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 32'h0, lat, ena_cnt, fa, err);
`ifdef ALIGN_CHECK_EN
        chk("misalign_latency", 32'(lat), 32'd1);
        chk("misalign_addr_err", 32'(err), 32'h1);
        chk("misalign_ram_cycles", 32'(ena_cnt), 32'd0);
        chk("misalign_rdata", rdata, prev_rdata);
`else
        chk("misalign_latency", 32'(lat), 32'd5);
        chk("misalign_addr_err", 32'(err), 32'h0);
        chk("misalign_ram_cycles", 32'(ena_cnt), 32'd4);
        chk("misalign_first_addr", 32'(fa), 32'h010);
        chk("misalign_rdata", rdata, 32'h01020304);
`endif
        @(negedge clk);

        // req held high for a whole word store: exactly one access
        preload(10'h070, 32'h0);
        we = 1'b1; w = 1'b1; h = 1'b0; b = 1'b0; z = 1'b0; addr = 32'h70; wdata = 32'h55667788;
        req = 1'b1;
        ena_cnt = 0; dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ram_ena) ena_cnt++;
            if (done) begin
                dones++;
                req = 1'b0;
            end
        end
        req = 1'b0;
        chk("held_req_ram_cycles", 32'(ena_cnt), 32'd4);
        chk("held_req_done_pulses", 32'(dones), 32'd1);
        chk("held_req_mem", mem_word(10'h070), 32'h55667788);
        chk("held_req_idle", 32'(busy), 32'h0);

        // Reset during the second ACCESS cycle of a word store
        preload(10'h080, 32'h0);
        we = 1'b1; w = 1'b1; h = 1'b0; b = 1'b0; z = 1'b0; addr = 32'h80; wdata = 32'hA1B2C3D4;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("abort_k0_addr", 32'(ram_addr), 32'h080);
        @(negedge clk);
        chk("abort_k1_addr", 32'(ram_addr), 32'h081);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_ram_ena", 32'(ram_ena), 32'h0);
        chk("abort_ram_wena", 32'(ram_wena), 32'h0);
        chk("abort_ram_addr", 32'(ram_addr), 32'h0);
        chk("abort_ram_wdata", 32'(ram_wdata), 32'h0);
        chk("abort_addr_err", 32'(addr_err), 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("abort_mem", mem_word(10'h080), 32'hA1000000);
        chk("abort_stays_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
